segment_scan_driver: RTL and testbench
======================================

// Module: segment_scan_driver
// PURPOSE
//   Time-multiplexed driver for an NUM_DIGITS common-anode 7-segment display.
//   Accepts a packed hex value over a valid/ready handshake and double-buffers it.
//   Updates apply only at frame boundaries, so the display never tears.
//   Scans one digit per dwell period, decodes its nibble to an active-low glyph and drives active-low anodes.
//   Sits between the value-producing logic (counters/debug regs) and the board display pins.
// PARAMETERS
//   NUM_DIGITS       4      number of digits; digit 0 = rightmost, least-significant nibble
//   REFRESH_DIV      50000  clk cycles per digit dwell; must be >= 2
//   DEAD_CYCLES      16     cycles at dwell start with all anodes off (anti-ghost); < REFRESH_DIV
//   BLANK_LEAD_ZEROS 1      1 = blank leading zero digits; digit 0 is never blanked
// PORTS
//   clk         in   1              system clock
//   rst_n       in   1              asynchronous active-low reset
//   in_valid    in   1              in_value/in_dp valid
//   in_ready    out  1              pending buffer empty; transfer on in_valid & in_ready
//   in_value    in   4*NUM_DIGITS   hex nibbles, [3:0] = digit 0
//   in_dp       in   NUM_DIGITS     decimal point per digit, 1 = lit
//   seg_n       out  7              segments, active-low: bit0=top, 1=top-right, 2=bot-right, 3=bottom, 4=bot-left, 5=top-left, 6=middle
//   dp_n        out  1              decimal point, active-low
//   an_n        out  NUM_DIGITS     anode enables, active-low, at most one low
//   digit_idx   out  $clog2(NUM_DIGITS) (min 1)  digit currently scanned
// BEHAVIOUR
//   Reset (async assert, sync deassert by clk): cnt=0, digit_idx=0, display reg=0, dp reg=0,
//     pending empty. Outputs: seg_n=7'h7F, dp_n=1, an_n=all 1. in_ready=1 after reset.
//   Dwell counter cnt runs 0..REFRESH_DIV-1.
//     tick = (cnt==REFRESH_DIV-1); on tick, cnt->0 and digit_idx increments mod NUM_DIGITS (wraps to 0).
//     frame_end = tick & (digit_idx==NUM_DIGITS-1).
//   Handshake / buffering:
//     in_ready = !pend_full.
//     Accept sets pend_full and captures in_value/in_dp into the pending regs.
//     On frame_end with pend_full=1: pending copies to the display regs and pend_full clears (in_ready=1 next cycle).
//     Accept cannot coincide with a transfer, since ready is low while full.
//     An accept on the frame_end cycle itself therefore waits for the NEXT frame_end.
//     in_valid while in_ready=0 is ignored; the producer holds the data.
//   Decode glyph table, active-low hex:
//     0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=18 A=08 b=03 C=46 d=21 E=06 F=0E.
//   Leading-zero blank: digit i (i>0) is blank when BLANK_LEAD_ZEROS and nibbles i..NUM_DIGITS-1 are all 0.
//     A blank digit drives seg_n=7'h7F; dp_n still follows the display dp bit.
//   Outputs are registered and lag the current cnt/digit_idx by 1 cycle:
//     an_n[digit_idx]=0 iff cnt >= DEAD_CYCLES, else all anodes are 1.
//     seg_n/dp_n = decode of the display digit_idx nibble/dp.
//   Mid-frame reset: all state and outputs return to reset values immediately; pending data is lost.
// TESTING (NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2)
//   1. Reset release, no load:
//      an_n=F and seg_n=7F on the first cycle; an_n=E from cycle 3 of dwell 0 (seg_n=40);
//      digits 1-3 have anode low with seg_n=7F; in_ready=1.
//   2. Load 16'h12AF, dp=4'b0100; after the first frame_end:
//      an_n=E->0E, D->08, B->24 with dp_n=0, 7->79.
//      No change to the glyphs before frame_end.
//   3. Load 16'h0005 -> digit0 seg_n=12, digits1-3 seg_n=7F.
//      Load 16'h0000 -> digit0=40, others 7F.
//      Load 16'h0500 -> digits0/1=40, digit2=12, digit3=7F.
//   4. Back-to-back loads A then B with in_valid held:
//      A accepted; in_ready=0 until the first frame_end;
//      B accepted the cycle after it is displayed; B is shown after the 2nd frame_end.
//   5. in_valid on the exact frame_end cycle with pending empty:
//      value displayed only after the following frame_end (32 cycles later).
//   6. rst_n low during the digit-2 dwell with pending full:
//      outputs F/7F/1 in the same cycle; after release, digit0=40 and in_ready=1.

Source files
------------

// File: rtl/segment_scan_driver.sv
// ---------------------------------------------------------------------------
// segment_scan_driver
//
// Time-multiplexed driver for a common-anode 7-segment display of NUM_DIGITS
// digits. A producer hands over a packed hex value (plus per-digit decimal
// points) on a valid/ready handshake. The value waits in a pending buffer and
// is copied to the display registers only at the end of a full scan frame, so
// a frame never mixes old and new digits. One digit is lit per dwell period.
// The first DEAD_CYCLES of every dwell keep all anodes off so the previous
// glyph cannot ghost onto the next digit.
//
// Ports
//   clk        : system clock
//   rst_n      : asynchronous active-low reset, deasserted synchronously
//   in_valid   : producer has in_value/in_dp available
//   in_ready   : pending buffer empty; a transfer happens on valid & ready
//   in_value   : hex nibbles, [3:0] = digit 0 (rightmost)
//   in_dp      : decimal point per digit, 1 = lit
//   seg_n      : segments, active-low (bit0 top ... bit6 middle)
//   dp_n       : decimal point, active-low
//   an_n       : anode enables, active-low, at most one low
//   digit_idx  : digit currently being scanned
// ---------------------------------------------------------------------------
module segment_scan_driver #(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_DIV      = 50000,
  parameter int DEAD_CYCLES      = 16,
  parameter bit BLANK_LEAD_ZEROS = 1'b1,
  localparam int IDX_W           = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NUM_DIGITS-1:0] in_value,
  input  logic [NUM_DIGITS-1:0]   in_dp,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [IDX_W-1:0]        digit_idx
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  // Active-low glyph for one hex nibble.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h18;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  logic [CNT_W-1:0]        cnt;
  logic                    tick;
  logic                    last_digit;
  logic                    frame_end;
  logic                    accept;

  logic                    pend_full;
  logic [4*NUM_DIGITS-1:0] pend_value;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [4*NUM_DIGITS-1:0] disp_value;
  logic [NUM_DIGITS-1:0]   disp_dp;

  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic                    upper_zero;
  logic                    anode_on;
  logic [6:0]              seg_next;
  logic                    dp_next;
  logic [NUM_DIGITS-1:0]   an_next;

  assign tick       = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign last_digit = (digit_idx == IDX_W'(NUM_DIGITS - 1));
  assign frame_end  = tick & last_digit;
  assign in_ready   = ~pend_full;
  // Ready is low whenever pending is full, so an accept can never collide
  // with the pending->display copy.
  assign accept     = in_valid & in_ready;
  assign anode_on   = (32'(cnt) >= 32'(DEAD_CYCLES));

  // Select the scanned digit and decide whether it is a leading zero.
  always_comb begin
    cur_nib    = 4'h0;
    cur_dp     = 1'b0;
    upper_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (IDX_W'(j) == digit_idx) begin
        cur_nib = disp_value[4*j +: 4];
        cur_dp  = disp_dp[j];
      end
      // Any non-zero nibble at or above the scanned digit keeps it visible.
      if (j >= int'(digit_idx) && disp_value[4*j +: 4] != 4'h0) begin
        upper_zero = 1'b0;
      end
    end
    // Digit 0 always shows, so a zero value still reads as "0".
    cur_blank = BLANK_LEAD_ZEROS && (digit_idx != '0) && upper_zero;
  end

  always_comb begin
    seg_next = cur_blank ? 7'h7F : hex_glyph(cur_nib);
    // The decimal point is independent of blanking.
    dp_next  = ~cur_dp;
    an_next  = '1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (anode_on && IDX_W'(j) == digit_idx) begin
        an_next[j] = 1'b0;
      end
    end
  end

  // Scan counters, handshake state, display registers and registered pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      digit_idx  <= '0;
      pend_full  <= 1'b0;
      disp_value <= '0;
      disp_dp    <= '0;
      seg_n      <= 7'h7F;
      dp_n       <= 1'b1;
      an_n       <= '1;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        digit_idx <= last_digit ? '0 : digit_idx + 1'b1;
      end

      if (accept) begin
        pend_full <= 1'b1;
      end else if (frame_end) begin
        pend_full <= 1'b0;
      end

      // New content only lands between frames, so no frame tears.
      if (frame_end && pend_full) begin
        disp_value <= pend_value;
        disp_dp    <= pend_dp;
      end

      seg_n <= seg_next;
      dp_n  <= dp_next;
      an_n  <= an_next;
    end
  end

  // Pending payload is only meaningful while pend_full is set, so it needs
  // no reset of its own.
  always_ff @(posedge clk) begin
    if (accept) begin
      pend_value <= in_value;
      pend_dp    <= in_dp;
    end
  end

endmodule

// File: tb/tb_segment_scan_driver.sv
module tb_segment_scan_driver;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int DC = 2;
  localparam int FRAME = ND * RD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_value = 16'h0;
  logic [3:0]  in_dp = 4'h0;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic [1:0]  digit_idx;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  segment_scan_driver #(
    .NUM_DIGITS(ND),
    .REFRESH_DIV(RD),
    .DEAD_CYCLES(DC),
    .BLANK_LEAD_ZEROS(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_value(in_value),
    .in_dp(in_dp),
    .seg_n(seg_n),
    .dp_n(dp_n),
    .an_n(an_n),
    .digit_idx(digit_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance past the active edge, then sample on the falling edge.
  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic goto(input int t);
    while (cyc < t) step();
  endtask

  function automatic int next_frame(input int c);
    return (c / FRAME + 1) * FRAME;
  endfunction

  // Sample where cnt==2 of digit d has just been registered: anode on.
  task automatic check_digit(input int base, input int d, input logic [6:0] seg, input logic dpn);
    logic [3:0] exp_an;
    exp_an = 4'hF;
    exp_an[d] = 1'b0;
    goto(base + RD * d + DC + 1);
    chk($sformatf("an_c%0d_d%0d", base, d), an_n, exp_an);
    chk($sformatf("seg_c%0d_d%0d", base, d), seg_n, seg);
    chk($sformatf("dp_c%0d_d%0d", base, d), dp_n, dpn);
  endtask

  task automatic check_frame(input int base, input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dpn);
    check_digit(base, 0, s0, dpn[0]);
    check_digit(base, 1, s1, dpn[1]);
    check_digit(base, 2, s2, dpn[2]);
    check_digit(base, 3, s3, dpn[3]);
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] dp, output int acc);
    in_valid = 1'b1;
    in_value = v;
    in_dp    = dp;
    for (int i = 0; i < 100 && !in_ready; i++) step();
    chk("load_ready", in_ready, 1'b1);
    step();
    acc = cyc;
    in_valid = 1'b0;
  endtask

  initial begin
    int a;
    int k;

    // Reset held, then released away from a clock edge.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_an", an_n, 4'hF);
    chk("rst_seg", seg_n, 7'h7F);
    chk("rst_dp", dp_n, 1'b1);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_idx", digit_idx, 2'd0);
    rst_n = 1'b1;
    cyc = 0;
    chk("first_an", an_n, 4'hF);
    chk("first_seg", seg_n, 7'h7F);

    // Dwell 0: dead cycles, then digit 0 lit with the zero glyph.
    step();
    chk("c1_an", an_n, 4'hF);
    chk("c1_seg", seg_n, 7'h40);
    step();
    chk("c2_an", an_n, 4'hF);
    step();
    chk("c3_an", an_n, 4'hE);
    chk("c3_seg", seg_n, 7'h40);
    chk("c3_idx", digit_idx, 2'd0);

    // Load 12AF with dp on digit 2; old (blank) glyphs stay until frame_end.
    load(16'h12AF, 4'b0100, a);
    chk("acc_cyc", a, 4);
    chk("busy_after_load", in_ready, 1'b0);
    goto(9);
    chk("c9_an_dead", an_n, 4'hF);
    chk("c9_idx", digit_idx, 2'd1);
    check_digit(0, 1, 7'h7F, 1'b1);
    check_digit(0, 2, 7'h7F, 1'b1);
    check_digit(0, 3, 7'h7F, 1'b1);
    goto(31);
    chk("c31_ready", in_ready, 1'b0);
    goto(32);
    chk("c32_ready", in_ready, 1'b1);
    chk("c32_seg_old", seg_n, 7'h7F);
    chk("c32_an", an_n, 4'h7);
    check_frame(32, 7'h0E, 7'h08, 7'h24, 7'h79, 4'b1011);

    // Leading-zero blanking; dp still shows on a blanked digit.
    load(16'h0005, 4'b1000, a);
    check_frame(next_frame(a), 7'h12, 7'h7F, 7'h7F, 7'h7F, 4'b0111);
    load(16'h0000, 4'b0000, a);
    check_frame(next_frame(a), 7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b1111);
    load(16'h0500, 4'b0000, a);
    check_frame(next_frame(a), 7'h40, 7'h40, 7'h12, 7'h7F, 4'b1111);

    // Back-to-back loads with valid held: BEEF then 9876.
    in_valid = 1'b1;
    in_value = 16'hBEEF;
    in_dp    = 4'b0000;
    chk("bb_ready0", in_ready, 1'b1);
    step();
    a = cyc;
    in_value = 16'h9876;
    chk("bb_busy", in_ready, 1'b0);
    k = next_frame(a);
    goto(k - 1);
    chk("bb_busy_pre_fe", in_ready, 1'b0);
    goto(k);
    chk("bb_ready_fe", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk("bb_b_acc", in_ready, 1'b0);
    check_frame(k, 7'h0E, 7'h06, 7'h06, 7'h03, 4'b1111);
    check_frame(k + FRAME, 7'h02, 7'h78, 7'h00, 7'h18, 4'b1111);

    // Accept exactly on a frame_end edge: waits one more frame.
    k = next_frame(cyc);
    goto(k - 1);
    chk("fe_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    in_value = 16'h4D0C;
    in_dp    = 4'b0000;
    step();
    in_valid = 1'b0;
    chk("fe_acc", in_ready, 1'b0);
    check_frame(k, 7'h02, 7'h78, 7'h00, 7'h18, 4'b1111);
    goto(k + FRAME - 1);
    chk("fe_busy_late", in_ready, 1'b0);
    check_frame(k + FRAME, 7'h46, 7'h40, 7'h21, 7'h19, 4'b1111);

    // Mid-frame reset during digit 2 with pending full.
    load(16'h1111, 4'b0100, a);
    k = next_frame(a);
    goto(k + 2);
    load(16'h2222, 4'b0000, a);
    goto(k + 2 * RD + 4);
    chk("pre_rst_busy", in_ready, 1'b0);
    chk("pre_rst_an", an_n, 4'hB);
    chk("pre_rst_seg", seg_n, 7'h79);
    chk("pre_rst_dp", dp_n, 1'b0);
    chk("pre_rst_idx", digit_idx, 2'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_an", an_n, 4'hF);
    chk("mid_rst_seg", seg_n, 7'h7F);
    chk("mid_rst_dp", dp_n, 1'b1);
    chk("mid_rst_ready", in_ready, 1'b1);
    chk("mid_rst_idx", digit_idx, 2'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    check_digit(0, 0, 7'h40, 1'b1);
    chk("post_rst_ready", in_ready, 1'b1);
    check_frame(FRAME, 7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b1111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
